// File: rtl/idex_hazard_ctrl_pkg.sv
// idex_hazard_ctrl_pkg: shared ID/EX sequencing types and constants
package idex_hazard_ctrl_pkg;
  typedef enum logic {RUN, MD_BUSY} md_state_e;
  localparam logic [4:0] REG_G0 = 5'd0;
  localparam logic [5:0] OP3_NOP = 6'b000010;
  localparam int DEF_MUL_LAT = 5;
  localparam int DEF_DIV_LAT = 34;
endpackage

// File: rtl/idex_hazard_ctrl_if.sv
// idex_hazard_ctrl_if: ID/EX hazard controller signal bundle
interface idex_hazard_ctrl_if #(parameter int CNT_W = 16);
  logic id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic [4:0] id_rd;
  logic id_uses_rs1;
  logic id_uses_rs2;
  logic id_uses_rd;
  logic id_md;
  logic id_md_div;
  logic ex_valid;
  logic [4:0] ex_rd;
  logic ex_is_load;
  logic ex_is_double;
  logic ex_cwp_change;
  logic ex_annul_slot;
  logic mem_ready;
  logic pc_write_en;
  logic ifid_write_en;
  logic idex_enable;
  logic idex_bubble;
  logic ifid_flush;
  logic md_busy;
  logic [CNT_W-1:0] stall_cycles;
  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2, id_uses_rd,
           id_md, id_md_div, ex_valid, ex_rd, ex_is_load, ex_is_double,
           ex_cwp_change, ex_annul_slot, mem_ready,
    input  pc_write_en, ifid_write_en, idex_enable, idex_bubble, ifid_flush,
           md_busy, stall_cycles
  );
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2, id_uses_rd,
           id_md, id_md_div, ex_valid, ex_rd, ex_is_load, ex_is_double,
           ex_cwp_change, ex_annul_slot, mem_ready,
    output pc_write_en, ifid_write_en, idex_enable, idex_bubble, ifid_flush,
           md_busy, stall_cycles
  );
endinterface

// File: rtl/idex_hazard_ctrl_reg_hazard_match.sv
// reg_hazard_match: does a source register collide with the EX destination (incl. LDD pair)
module reg_hazard_match
  import idex_hazard_ctrl_pkg::*;
(
  input  logic [4:0] r,
  input  logic [4:0] ex_rd,
  input  logic       ex_is_double,
  output logic       m
);
  assign m = (r != REG_G0) && ((r == ex_rd) || (ex_is_double && r == {ex_rd[4:1], 1'b1}));
endmodule

// File: rtl/idex_hazard_ctrl.sv
// idex_hazard_ctrl: ID/EX load/bubble/flush sequencing with load-use, CWP and MUL/DIV holds
module idex_hazard_ctrl
  import idex_hazard_ctrl_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT,
  parameter int CNT_W   = 16
)(
  input logic clk,
  input logic reset,
  idex_hazard_ctrl_if.slave bus
);
  localparam int MD_W = $clog2(DIV_LAT);
  localparam logic [MD_W-1:0] MUL_CNT = MD_W'(MUL_LAT - 1);
  localparam logic [MD_W-1:0] DIV_CNT = MD_W'(DIV_LAT - 1);
  md_state_e state, state_n;
  logic [MD_W-1:0] md_cnt, md_cnt_n;
  logic [CNT_W-1:0] stall_q;
  logic m_rs1, m_rs2, m_rd;
  logic load_use, cwp_haz, annul, haz, hold, issue, pc_en;
  reg_hazard_match u_m_rs1 (.r(bus.id_rs1), .ex_rd(bus.ex_rd), .ex_is_double(bus.ex_is_double), .m(m_rs1));
  reg_hazard_match u_m_rs2 (.r(bus.id_rs2), .ex_rd(bus.ex_rd), .ex_is_double(bus.ex_is_double), .m(m_rs2));
  reg_hazard_match u_m_rd  (.r(bus.id_rd),  .ex_rd(bus.ex_rd), .ex_is_double(bus.ex_is_double), .m(m_rd));
  assign load_use = bus.ex_valid & bus.ex_is_load & bus.id_valid &
                    ((bus.id_uses_rs1 & m_rs1) | (bus.id_uses_rs2 & m_rs2) | (bus.id_uses_rd & m_rd));
  assign cwp_haz  = bus.ex_valid & bus.ex_cwp_change & bus.id_valid;
  assign annul    = bus.ex_annul_slot & bus.id_valid;
  assign haz      = load_use | cwp_haz;
  assign hold     = ~bus.mem_ready | (state == MD_BUSY);
  assign issue    = ~hold & ~annul & ~haz & bus.id_valid & bus.id_md;
  assign pc_en    = ~reset & ~hold & (annul | ~haz);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state  <= RUN;
      md_cnt <= '0;
    end else begin
      state  <= state_n;
      md_cnt <= md_cnt_n;
    end
  // The MD countdown runs regardless of mem_ready so the result is ready on schedule
  always_comb begin
    state_n  = state == MD_BUSY ? (md_cnt == MD_W'(1) ? RUN : MD_BUSY) : (issue ? MD_BUSY : RUN);
    md_cnt_n = state == MD_BUSY ? (md_cnt == MD_W'(1) ? '0 : md_cnt - MD_W'(1))
                                : (issue ? (bus.id_md_div ? DIV_CNT : MUL_CNT) : md_cnt);
  end
  always_comb begin
    bus.pc_write_en   = pc_en;
    bus.ifid_write_en = pc_en;
    bus.idex_enable   = ~reset & ~hold;
    bus.idex_bubble   = ~reset & ~hold & (annul | haz);
    bus.ifid_flush    = ~reset & ~hold & annul;
    bus.md_busy       = ~reset & (state == MD_BUSY);
    bus.stall_cycles  = stall_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) stall_q <= '0;
    else if (!pc_en && stall_q != '1) stall_q <= stall_q + 1'b1;
endmodule

// File: tb/tb_idex_hazard_ctrl.sv
// tb_idex_hazard_ctrl: directed + randomized check against a cycle-level behavioural model
module tb_idex_hazard_ctrl;
  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 34;
  localparam int CNT_W   = 6;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int busy_left = 0;
  int stall_cnt = 0;
  idex_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();
  idex_hazard_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit hit(input logic [4:0] r);
    return r != 0 && (r == bus.ex_rd || (bus.ex_is_double && r == (bus.ex_rd | 5'd1)));
  endfunction
  task automatic idle();
    {bus.id_valid, bus.id_uses_rs1, bus.id_uses_rs2, bus.id_uses_rd, bus.id_md, bus.id_md_div} = '0;
    {bus.id_rs1, bus.id_rs2, bus.id_rd, bus.ex_rd} = '0;
    {bus.ex_valid, bus.ex_is_load, bus.ex_is_double, bus.ex_cwp_change, bus.ex_annul_slot} = '0;
    bus.mem_ready = 1'b1;
  endtask
  task automatic step();
    bit lu, cw, an, issue;
    bit e_pc, e_ex, e_bub, e_fl;
    #1;
    lu = bus.ex_valid && bus.ex_is_load && bus.id_valid &&
         ((bus.id_uses_rs1 && hit(bus.id_rs1)) || (bus.id_uses_rs2 && hit(bus.id_rs2)) ||
          (bus.id_uses_rd && hit(bus.id_rd)));
    cw = bus.ex_valid && bus.ex_cwp_change && bus.id_valid;
    an = bus.ex_annul_slot && bus.id_valid;
    issue = 0;
    if (reset || !bus.mem_ready || busy_left > 0) {e_pc, e_ex, e_bub, e_fl} = 4'b0000;
    else if (an) {e_pc, e_ex, e_bub, e_fl} = 4'b1111;
    else if (lu || cw) {e_pc, e_ex, e_bub, e_fl} = 4'b0110;
    else begin
      {e_pc, e_ex, e_bub, e_fl} = 4'b1100;
      issue = bus.id_valid && bus.id_md;
    end
    check("pc_we", 32'(bus.pc_write_en), 32'(e_pc));
    check("ifid_we", 32'(bus.ifid_write_en), 32'(e_pc));
    check("idex_en", 32'(bus.idex_enable), 32'(e_ex));
    check("bubble", 32'(bus.idex_bubble), 32'(e_bub));
    check("flush", 32'(bus.ifid_flush), 32'(e_fl));
    check("md_busy", 32'(bus.md_busy), 32'(!reset && busy_left > 0));
    check("stall_cycles", 32'(bus.stall_cycles), reset ? 32'd0 : 32'(stall_cnt));
    if (reset) begin
      busy_left = 0;
      stall_cnt = 0;
    end else begin
      if (busy_left > 0) busy_left--;
      else if (issue) busy_left = (bus.id_md_div ? DIV_LAT : MUL_LAT) - 1;
      if (!e_pc && stall_cnt < CNT_MAX) stall_cnt++;
    end
    @(negedge clk);
  endtask
  initial begin
    idle();
    @(negedge clk);
    step();
    reset = 1'b0;
    bus.ex_valid = 1; bus.ex_is_load = 1; bus.ex_rd = 5;
    bus.id_valid = 1; bus.id_uses_rs1 = 1; bus.id_rs1 = 5;
    step();
    idle();
    step();
    check("ld_use_stall_count", 32'(bus.stall_cycles), 32'd1);
    bus.ex_valid = 1; bus.ex_is_load = 1; bus.ex_is_double = 1; bus.ex_rd = 6;
    bus.id_valid = 1; bus.id_uses_rs2 = 1; bus.id_rs2 = 7; bus.ex_annul_slot = 1;
    step();
    idle();
    bus.id_valid = 1; bus.id_md = 1;
    step();
    idle();
    repeat (MUL_LAT - 1) begin
      check("mul_hold", 32'(bus.idex_enable), 32'd0);
      step();
    end
    check("mul_done", 32'(bus.idex_enable), 32'd1);
    bus.id_valid = 1; bus.id_md = 1; bus.id_md_div = 1;
    step();
    idle();
    repeat (23) begin
      bus.mem_ready = 1'($urandom_range(0, 1));
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    for (int i = 0; i < 5000; i++) begin
      reset = ($urandom_range(0, 399) == 0);
      bus.id_valid = ($urandom_range(0, 9) < 8);
      bus.id_rs1 = 5'($urandom_range(0, 7));
      bus.id_rs2 = 5'($urandom_range(0, 7));
      bus.id_rd = 5'($urandom_range(0, 7));
      bus.id_uses_rs1 = 1'($urandom_range(0, 1));
      bus.id_uses_rs2 = 1'($urandom_range(0, 1));
      bus.id_uses_rd = ($urandom_range(0, 3) == 0);
      bus.id_md = ($urandom_range(0, 11) == 0);
      bus.id_md_div = ($urandom_range(0, 3) == 0);
      bus.ex_valid = ($urandom_range(0, 9) < 8);
      bus.ex_rd = 5'($urandom_range(0, 7));
      bus.ex_is_load = ($urandom_range(0, 2) == 0);
      bus.ex_is_double = ($urandom_range(0, 3) == 0);
      bus.ex_cwp_change = ($urandom_range(0, 9) == 0);
      bus.ex_annul_slot = ($urandom_range(0, 9) == 0);
      bus.mem_ready = ($urandom_range(0, 9) < 8);
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/idex_hazard_ctrl.md
Name: idex_hazard_ctrl

Overview:
Sequencing controller for the ID/EX pipeline register of the SPARC integer pipeline. It drives the ID/EX load enable (ex_ready), the PC and IF/ID write enables, bubble insertion and delay-slot flush. It resolves load-use and CWP hazards, holds the pipe for multi-cycle MUL/DIV in EX, and honours downstream memory stalls. It also keeps a saturating stall-cycle counter.

Parameters:
MUL_LAT, 5, total EX cycles for UMUL/SMUL; must be >= 2
DIV_LAT, 34, total EX cycles for UDIV/SDIV; must be >= 2
CNT_W, 16, width of stall-cycle counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_rs1  in  5  ID source reg 1
id_rs2  in  5  ID source reg 2
id_rd  in  5  ID rd (read by stores)
id_uses_rs1  in  1  ID reads rs1
id_uses_rs2  in  1  ID reads rs2 (0 when i=1)
id_uses_rd  in  1  ID reads rd (ST/STD)
id_md  in  1  ID instruction is MUL/DIV
id_md_div  in  1  1=DIV, 0=MUL (valid with id_md)
ex_valid  in  1  EX holds a real instruction
ex_rd  in  5  EX destination reg
ex_is_load  in  1  EX is a load
ex_is_double  in  1  EX is LDD (writes rd and rd|1)
ex_cwp_change  in  1  EX is SAVE/RESTORE
ex_annul_slot  in  1  EX branch annuls delay slot now in ID
mem_ready  in  1  downstream stage can accept
pc_write_en  out  1  PC update enable
ifid_write_en  out  1  IF/ID register load enable
idex_enable  out  1  ID/EX load enable (drives ex_ready)
idex_bubble  out  1  force NOP into ID/EX (regWrite/regWriteDouble = 0, op3 = NOP)
ifid_flush  out  1  clear IF/ID to NOP
md_busy  out  1  multi-cycle op occupying EX
stall_cycles  out  CNT_W  saturating count of cycles with pc_write_en=0

Behaviour:
- State: RUN, MD_BUSY. Register md_cnt is clog2(DIV_LAT) bits. All flops reset asynchronously: state=RUN, md_cnt=0, stall_cycles=0.
- While reset is high, all outputs are 0.
- Register match (m): reg r != 0 and (r == ex_rd, or ex_is_double and r == {ex_rd[4:1],1'b1}). %g0 never hazards.
- load_use = ex_valid & ex_is_load & id_valid & ((id_uses_rs1 & m(id_rs1)) | (id_uses_rs2 & m(id_rs2)) | (id_uses_rd & m(id_rd))).
- cwp_haz = ex_valid & ex_cwp_change & id_valid.
- Enables are combinational from state and inputs. Priority runs highest first:
  1. mem_ready=0: pc_write_en, ifid_write_en and idex_enable = 0; bubble = 0; flush = 0.
  2. state MD_BUSY: same three enables = 0; md_busy=1.
  3. ex_annul_slot & id_valid: pc_write_en=1, ifid_write_en=1, idex_enable=1, idex_bubble=1, ifid_flush=1. Annul wins over load_use/cwp_haz.
  4. load_use | cwp_haz: pc_write_en=0, ifid_write_en=0, idex_enable=1, idex_bubble=1. This is exactly one bubble, since the load leaves EX.
  5. Otherwise all enables = 1; bubble and flush = 0.
- MD issue occurs when case 5 applies with id_valid & id_md.
  - Next state is MD_BUSY; md_cnt <= (id_md_div ? DIV_LAT : MUL_LAT) - 1.
- In MD_BUSY, md_cnt decrements every cycle, independent of mem_ready.
  - When md_cnt == 1: next state RUN, md_cnt <= 0.
  - Result: LAT-1 hold cycles after the issue cycle, and the next ID/EX load occurs LAT cycles after issue.
- stall_cycles increments when reset is low and pc_write_en=0; it holds at all-ones.
- Reset asserted mid-MD_BUSY returns immediately to RUN; the EX op is discarded by the pipeline reset.
- id_md with id_valid=0 is ignored.

Decomposition:
- Shared pipeline package holds: state enum (RUN, MD_BUSY), REG_G0 = 5'd0, NOP op3 constant, and default MUL_LAT/DIV_LAT localparams.
- One natural sub-module: reg_hazard_match. Combinational; takes a 5-bit register plus the ex_rd/ex_is_double fields and produces m. It is instantiated three times.

Test Plan:
- EX LD rd=5, ID ADD rs1=5 -> one cycle with pc_write_en=0, idex_enable=1, idex_bubble=1; the next cycle is normal; stall_cycles=1.
- EX LD rd=0, ID ADD rs1=0 -> no stall. EX LDD rd=6, ID ADD rs2=7 (i=0) -> one bubble. Same case with i=1 (id_uses_rs2=0) -> no stall.
- Issue MUL at cycle T (MUL_LAT=5) -> idex_enable=0 and md_busy=1 for T+1..T+4; idex_enable=1 at T+5. With DIV_LAT=34 -> 33 hold cycles.
- ex_annul_slot=1 coincident with load_use -> ifid_flush=1, idex_bubble=1, pc_write_en=1; no extra stall cycle.
- mem_ready=0 for 3 cycles during RUN -> all enables 0; stall_cycles +3. mem_ready=0 during MD_BUSY -> md_cnt still reaches RUN on schedule.
- Assert reset during MD_BUSY (md_cnt=10) -> outputs 0 immediately; after release state=RUN and enables=1. Force stall_cycles to 16'hFFFF, then stall -> it stays 16'hFFFF.
